wb_sdrc_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller (wb2sdrc front end) between two requesters, e.g. a CPU port and a DMA/test port. It performs round-robin arbitration at Wishbone cycle (cyc) granularity and locks the grant for the whole cycle. A per-transfer watchdog terminates a stalled transfer with an error and releases the bus. It sits in the wb_clk_i domain directly in front of the SDRAM controller top.

---
 rtl/wb_sdrc_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_wb_sdrc_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sdrc_arbiter.sv
// wb_sdrc_arbiter
// Two-master Wishbone arbiter in front of the SDRAM controller slave port.
// The grant is round-robin at Wishbone cycle granularity and is held for
// the whole cyc. A per-transfer watchdog ends a stalled strobe with err and
// releases the bus. At least one idle cycle always separates two grants.

module wb_sdrc_arbiter #(
    parameter int AW      = 26,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    // master 0
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    // master 1
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    // shared slave (SDRAM controller)
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [SW-1:0] s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    // Watchdog sizing. A zero TIMEOUT keeps a 1-bit counter that never moves.
    localparam bit          TO_EN   = (TIMEOUT > 0);
    localparam int          CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;   // 1: master 1 held the bus last
    logic [CW-1:0] to_cnt_q, to_cnt_d;

    logic          stb_act;                  // strobe currently routed to the slave
    logic          timeout_hit;              // watchdog expires this cycle

    // Read data goes to both masters; only the ack qualifies it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign stb_act = !wb_rst_i &&
                     (((state_q == GNT0) && m0_stb_i) ||
                      ((state_q == GNT1) && m1_stb_i));

    // Ack in the last allowed cycle wins over the timeout.
    assign timeout_hit = TO_EN && stb_act && !s_ack_i && (to_cnt_q == TO_LAST);

    // Route the granted master onto the slave port and steer ack/err back.
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;

        if (!wb_rst_i) begin
            unique case (state_q)
                GNT0: begin
                    gnt_o    = 2'b01;
                    s_cyc_o  = m0_cyc_i;
                    s_stb_o  = m0_stb_i;
                    s_we_o   = m0_we_i;
                    s_sel_o  = m0_sel_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    m0_ack_o = s_ack_i & m0_stb_i;
                    m0_err_o = timeout_hit;
                end
                GNT1: begin
                    gnt_o    = 2'b10;
                    s_cyc_o  = m1_cyc_i;
                    s_stb_o  = m1_stb_i;
                    s_we_o   = m1_we_i;
                    s_sel_o  = m1_sel_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    m1_ack_o = s_ack_i & m1_stb_i;
                    m1_err_o = timeout_hit;
                end
                default: begin
                    // IDLE: nothing routed, stale slave acks are dropped here.
                end
            endcase
        end
    end

    // Next-state, round-robin choice and watchdog count.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        to_cnt_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_gnt_q) begin
                        state_d    = GNT0;
                        last_gnt_d = 1'b0;
                    end else begin
                        state_d    = GNT1;
                        last_gnt_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d    = GNT0;
                    last_gnt_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d    = GNT1;
                    last_gnt_d = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || timeout_hit) begin
                    state_d = IDLE;
                end else if (TO_EN && stb_act && !s_ack_i) begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
            end
            GNT1: begin
                if (!m1_cyc_i || timeout_hit) begin
                    state_d = IDLE;
                end else if (TO_EN && stb_act && !s_ack_i) begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, last-grant and watchdog registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (wb_rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// tb_wb_sdrc_arbiter
// Table of per-cycle control vectors followed by hand-written sequences for
// write datapath, round robin, burst lock, watchdog and reset mid-transfer.

module tb_wb_sdrc_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we;
    logic [SW-1:0] m0_sel;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_wdat, m0_rdat;
    logic          m0_ack, m0_err;
    logic          m1_cyc, m1_stb, m1_we;
    logic [SW-1:0] m1_sel;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_wdat, m1_rdat;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [SW-1:0] s_sel;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat, s_rdat;
    logic          s_ack;
    logic [1:0]    gnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    wb_sdrc_arbiter #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb), .m0_we_i (m0_we),
        .m0_sel_i (m0_sel), .m0_adr_i (m0_adr), .m0_dat_i (m0_wdat),
        .m0_dat_o (m0_rdat), .m0_ack_o (m0_ack), .m0_err_o (m0_err),
        .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb), .m1_we_i (m1_we),
        .m1_sel_i (m1_sel), .m1_adr_i (m1_adr), .m1_dat_i (m1_wdat),
        .m1_dat_o (m1_rdat), .m1_ack_o (m1_ack), .m1_err_o (m1_err),
        .s_cyc_o  (s_cyc),  .s_stb_o  (s_stb),  .s_we_o   (s_we),
        .s_sel_o  (s_sel),  .s_adr_o  (s_adr),  .s_dat_o  (s_wdat),
        .s_dat_i  (s_rdat), .s_ack_i  (s_ack),
        .gnt_o    (gnt)
    );

    always #5 clk = ~clk;

    // One control vector: inputs for one cycle and the expected outputs
    // packed as {gnt[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err}.
    typedef struct packed {
        logic       rst;
        logic       c0, s0, c1, s1, ack;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int   err_cyc;
        logic found;
        logic flag;
        logic [1:0] exp_g;

        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_wdat = '0;
        s_rdat = '0; s_ack = 0;

        //            rst c0 s0 c1 s1 ack  gnt scyc sstb a0 a1 e0 e1
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'b00_0_0_0_0_0_0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'b00_0_0_0_0_0_0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00_0_0_0_0_0_0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b01_1_1_0_0_0_0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'b01_1_1_1_0_0_0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b01_0_0_0_0_0_0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b00_0_0_0_0_0_0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'b10_1_1_0_0_0_0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'b10_1_1_0_1_0_0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10_0_0_0_0_0_0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'b01_1_1_1_0_0_0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'b01_0_0_0_0_0_0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'b10_1_1_0_1_0_0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'b10_1_0_0_0_0_0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'b10_0_0_0_0_0_0};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'b00_0_0_0_0_0_0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'b01_1_1_0_0_0_0};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'b01_1_1_1_0_0_0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'b01_1_0_0_0_0_0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b01_0_0_0_0_0_0};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'b00_0_0_0_0_0_0};

        for (int i = 0; i < 24; i++) begin
            tick();
            rst = vecs[i].rst;
            m0_cyc = vecs[i].c0; m0_stb = vecs[i].s0;
            m1_cyc = vecs[i].c1; m1_stb = vecs[i].s1;
            s_ack  = vecs[i].ack;
            #3;
            check($sformatf("vec%0d", i),
                  {gnt, s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err}, vecs[i].exp);
        end

        // ---- single write from master 1, slave acks 3 cycles after stb ----
        do_reset();
        m0_adr = 26'h3FFFFFF; m0_wdat = 32'h0; m0_sel = 4'h1; m0_we = 1'b0;
        m1_cyc = 1; m1_stb = 1; m1_we = 1;
        m1_adr = 26'h0000100; m1_wdat = 32'hDEADBEEF; m1_sel = 4'hF;
        #3;
        check("wr_idle_gnt", gnt, 2'b00);
        tick();
        #3;
        check("wr_gnt", {gnt, s_cyc, s_stb}, {2'b10, 1'b1, 1'b1});
        check("wr_adr", s_adr, 26'h0000100);
        check("wr_dat", s_wdat, 32'hDEADBEEF);
        check("wr_sel_we", {s_sel, s_we}, {4'hF, 1'b1});
        flag = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (m0_ack || m1_ack) flag = 1'b1;
            tick();
            #3;
        end
        check("wr_no_early_ack", flag, 1'b0);
        s_ack = 1;
        #1;
        check("wr_ack", {m1_ack, m0_ack}, 2'b10);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        #3;
        check("wr_ack_pulse", {gnt, s_cyc, m1_ack}, {2'b10, 1'b0, 1'b0});
        tick();
        #3;
        check("wr_release", gnt, 2'b00);

        // ---- round robin: 4 single reads per master, both always requesting ----
        do_reset();
        m0_adr = 26'h0000040; m1_adr = 26'h0000080;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < 8; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                #3;
                if (gnt != 2'b00) begin
                    found = 1'b1;
                    break;
                end
                tick();
            end
            check($sformatf("rr%0d_found", i), found, 1'b1);
            s_ack  = 1;
            s_rdat = (exp_g == 2'b01) ? 32'h12345678 : 32'h0BADF00D;
            #1;
            check($sformatf("rr%0d_gnt", i), gnt, exp_g);
            check($sformatf("rr%0d_ack", i), {m1_ack, m0_ack}, exp_g);
            if (exp_g == 2'b01) check($sformatf("rr%0d_m0dat", i), m0_rdat, 32'h12345678);
            else                check($sformatf("rr%0d_m1dat", i), m1_rdat, 32'h0BADF00D);
            tick();
            s_ack = 0;
            if (exp_g == 2'b01) begin m0_cyc = 0; m0_stb = 0; end
            else                begin m1_cyc = 0; m1_stb = 0; end
            tick();
            m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
            #3;
            check($sformatf("rr%0d_idle", i), {gnt, s_cyc}, 3'b000);
            tick();
        end
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;

        // ---- burst lock: m0 keeps cyc for 8 strobes while m1 waits ----
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        for (int b = 0; b < 8; b++) begin
            s_ack = 1;
            #3;
            check($sformatf("burst%0d", b), {gnt, m0_ack, m1_ack}, {2'b01, 1'b1, 1'b0});
            tick();
        end
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #3;
        check("burst_end", {gnt, s_cyc}, {2'b01, 1'b0});
        tick();
        #3;
        check("burst_idle", gnt, 2'b00);
        tick();
        #3;
        check("burst_m1", gnt, 2'b10);
        m1_cyc = 0; m1_stb = 0;

        // ---- watchdog: slave never acks m0, m1 waiting ----
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 0;
        tick();                        // first cycle with m0 strobe on the slave
        err_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            #3;
            if (m0_err) begin
                err_cyc = k;
                break;
            end
            tick();
        end
        check("to_err_cycle", err_cyc, TO - 1);
        check("to_err_no_ack", {m0_ack, m1_err, s_cyc}, {1'b0, 1'b0, 1'b1});
        tick();
        s_ack = 1;                     // late ack while idle
        #3;
        check("to_release", {gnt, s_cyc, m0_err}, 4'b0000);
        check("to_stale_ack", {m0_ack, m1_ack}, 2'b00);
        tick();
        s_ack = 0; m1_stb = 1;
        #3;
        check("to_m1_next", gnt, 2'b10);
        // ack arriving in the last allowed cycle beats the timeout
        flag = 1'b0;
        for (int k = 0; k < TO - 1; k++) begin
            if (m1_err) flag = 1'b1;
            tick();
            #3;
        end
        check("to_edge_no_early_err", flag, 1'b0);
        s_ack = 1;
        #1;
        check("to_edge_ack_wins", {m1_ack, m1_err}, 2'b10);

        // ---- reset in the middle of a pending read on master 1 ----
        tick();
        s_ack = 0;
        #3;
        check("rst_pre", {gnt, s_cyc, s_stb}, {2'b10, 1'b1, 1'b1});
        tick();
        rst = 1; s_ack = 1;
        #3;
        check("rst_mid", {gnt, s_cyc, m1_ack, m1_err}, 5'b00000);
        tick();
        rst = 0; s_ack = 0;
        m0_cyc = 1; m0_stb = 0; m1_cyc = 1; m1_stb = 0;
        #3;
        check("rst_after_idle", gnt, 2'b00);
        tick();
        #3;
        check("rst_after_m0", gnt, 2'b01);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
